counter_core: RTL and testbench

//   Free-running binary up-counter. Increments once per rising clock edge
//   and wraps at a programmable modulus.

---
 rtl/counter_core.sv | 87 ++++++++
 tb/tb_counter_core.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/counter_core.sv
// rtl/counter_core.sv - free-running modulo up-counter with wrap pulse
//
// Purpose:
//   Binary up-counter that advances by STEP on every rising clock edge.
//   When the next value would exceed MAX_VALUE, or would overflow WIDTH
//   bits, it returns to RESET_VALUE and raises wrap for one cycle.
//   It serves as a generic timebase or sequence source.
//
// Optional feature (macro COUNTER_LOAD_EN):
//   Adds a count enable and a synchronous load with clamping.
//   Priority is reset, then load, then en.
//   With the macro undefined the counter counts on every cycle.
//
// Ports:
//   value      out WIDTH  current count, registered
//   clk        in  1      rising-edge clock
//   reset      in  1      asynchronous active-low reset
//   wrap       out 1      registered pulse, high in the cycle after a wrap
//   en         in  1      count enable (COUNTER_LOAD_EN only)
//   load       in  1      synchronous load strobe (COUNTER_LOAD_EN only)
//   load_value in  WIDTH  value to load, clamped to MAX_VALUE (COUNTER_LOAD_EN only)

module counter_core #(
    parameter int unsigned       WIDTH       = 8,
    parameter int unsigned       STEP        = 1,
    parameter logic [WIDTH-1:0]  MAX_VALUE   = {WIDTH{1'b1}},
    parameter logic [WIDTH-1:0]  RESET_VALUE = '0
) (
    output logic [WIDTH-1:0] value,
    input  logic             clk,
    input  logic             reset,
    output logic             wrap
`ifdef COUNTER_LOAD_EN
    ,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value
`endif
);

    // One extra bit keeps value+STEP from silently wrapping past 2**WIDTH-1.
    localparam logic [WIDTH:0] STEP_EXT = (WIDTH+1)'(STEP);
    localparam logic [WIDTH:0] MAX_EXT  = {1'b0, MAX_VALUE};

    logic [WIDTH-1:0] value_q, value_d;
    logic             wrap_q, wrap_d;
    logic [WIDTH:0]   sum;

    always_comb begin
        sum     = {1'b0, value_q} + STEP_EXT;
        value_d = value_q;
        wrap_d  = 1'b0;
`ifdef COUNTER_LOAD_EN
        if (load) begin
            value_d = (load_value > MAX_VALUE) ? MAX_VALUE : load_value;
        end else if (en) begin
            if (sum > MAX_EXT) begin
                value_d = RESET_VALUE;
                wrap_d  = 1'b1;
            end else begin
                value_d = sum[WIDTH-1:0];
            end
        end
`else
        if (sum > MAX_EXT) begin
            value_d = RESET_VALUE;
            wrap_d  = 1'b1;
        end else begin
            value_d = sum[WIDTH-1:0];
        end
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            value_q <= RESET_VALUE;
            wrap_q  <= 1'b0;
        end else begin
            value_q <= value_d;
            wrap_q  <= wrap_d;
        end
    end

    assign value = value_q;
    assign wrap  = wrap_q;

endmodule

// File: tb/tb_counter_core.sv
// tb/tb_counter_core.sv - self-checking bench for counter_core

module tb_counter_core;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic [7:0] v_a, v_b, v_c;
    logic       w_a, w_b, w_c;

    int n_cmp = 0;
    int n_bad = 0;
    int k     = 0;   // rising edges seen with reset high since last reset

    counter_core u_a (
        .value(v_a), .clk(clk), .reset(reset), .wrap(w_a)
`ifdef COUNTER_LOAD_EN
        , .en(1'b1), .load(1'b0), .load_value(8'h00)
`endif
    );

    counter_core #(.WIDTH(8), .STEP(1), .MAX_VALUE(8'd9), .RESET_VALUE(8'd0)) u_b (
        .value(v_b), .clk(clk), .reset(reset), .wrap(w_b)
`ifdef COUNTER_LOAD_EN
        , .en(1'b1), .load(1'b0), .load_value(8'h00)
`endif
    );

    counter_core #(.WIDTH(8), .STEP(4), .MAX_VALUE(8'd10), .RESET_VALUE(8'd0)) u_c (
        .value(v_c), .clk(clk), .reset(reset), .wrap(w_c)
`ifdef COUNTER_LOAD_EN
        , .en(1'b1), .load(1'b0), .load_value(8'h00)
`endif
    );

`ifdef COUNTER_LOAD_EN
    logic       reset_l, en_l, load_l, w_l;
    logic [7:0] lv_l, v_l;
    int         m_l;
    logic       m_w;

    counter_core #(.WIDTH(8), .STEP(1), .MAX_VALUE(8'hF8), .RESET_VALUE(8'd0)) u_l (
        .value(v_l), .clk(clk), .reset(reset_l), .wrap(w_l),
        .en(en_l), .load(load_l), .load_value(lv_l)
    );
`endif

    // Reference: the counter visits 0, STEP, 2*STEP, ... while <= MAX, so its
    // period is MAX/STEP+1 edges; wrap marks each return to zero.
    function automatic int exp_val(int kk, int step, int maxv);
        int p;
        p = maxv / step + 1;
        return step * (kk % p);
    endfunction

    function automatic int exp_wrap(int kk, int step, int maxv);
        int p;
        p = maxv / step + 1;
        return ((kk > 0) && (kk % p == 0)) ? 1 : 0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_a_val"},  {24'd0, v_a}, exp_val(k, 1, 255));
        chk({tag, "_a_wrap"}, {31'd0, w_a}, exp_wrap(k, 1, 255));
        chk({tag, "_b_val"},  {24'd0, v_b}, exp_val(k, 1, 9));
        chk({tag, "_b_wrap"}, {31'd0, w_b}, exp_wrap(k, 1, 9));
        chk({tag, "_c_val"},  {24'd0, v_c}, exp_val(k, 4, 10));
        chk({tag, "_c_wrap"}, {31'd0, w_c}, exp_wrap(k, 4, 10));
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        #1;
        if (reset) k++;
        check_all(tag);
    endtask

`ifdef COUNTER_LOAD_EN
    task automatic tick_l(input string tag);
        @(posedge clk);
        #1;
        if (!reset_l) begin
            m_l = 0;
            m_w = 1'b0;
        end else if (load_l) begin
            m_l = (int'(lv_l) > 'hF8) ? 'hF8 : int'(lv_l);
            m_w = 1'b0;
        end else if (en_l) begin
            m_w = (m_l == 'hF8);
            m_l = (m_l + 1) % ('hF8 + 1);
        end else begin
            m_w = 1'b0;
        end
        chk({tag, "_val"},  {24'd0, v_l}, m_l[31:0]);
        chk({tag, "_wrap"}, {31'd0, w_l}, {31'd0, m_w});
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d;
        int n;
        reset = 1'b1;
`ifdef COUNTER_LOAD_EN
        reset_l = 1'b0; en_l = 1'b0; load_l = 1'b0; lv_l = 8'h00;
        m_l = 0; m_w = 1'b0;
`endif
        // First reset pulse, t=17..28; value must clear before any clock edge.
        #17 reset = 1'b0;
        k = 0;
        #1 check_all("rst1_async");
        @(posedge clk); #1 check_all("rst1_held");
        #2 reset = 1'b1;                       // t=28
        for (int i = 0; i < 3; i++) tick("count1");

        // Second pulse t=57..68 mid-count.
        #1 reset = 1'b0;                       // t=57
        k = 0;
        #1 check_all("rst2_async");            // t=58
        @(posedge clk); #1 check_all("rst2_held");
        #2 reset = 1'b1;                       // t=68

        // Full revolution of the default counter: ends at 0x00 with wrap.
        for (int i = 0; i < 256; i++) tick("run256");
        chk("run256_end_val",  {24'd0, v_a}, 32'h0);
        chk("run256_end_wrap", {31'd0, w_a}, 32'h1);

        // Reset arriving while a wrap pulse is being shown.
        #1 reset = 1'b0;
        k = 0;
        #1 check_all("rst_in_wrap");
        @(posedge clk); #1 check_all("rst_in_wrap_held");
        #2 reset = 1'b1;
        for (int i = 0; i < 3; i++) tick("after_wrap_rst");

        // Randomized run lengths and asynchronous reset placements.
        for (int r = 0; r < 20; r++) begin
            n = $urandom_range(1, 40);
            for (int i = 0; i < n; i++) tick("rand_run");
            d = $urandom_range(1, 3);
            #d reset = 1'b0;
            k = 0;
            #1 check_all("rand_rst_async");
            n = $urandom_range(0, 2);
            for (int i = 0; i < n; i++) tick("rand_rst_held");
            d = $urandom_range(1, 3);
            #d reset = 1'b1;
        end
        for (int i = 0; i < 12; i++) tick("rand_tail");

`ifdef COUNTER_LOAD_EN
        @(posedge clk); #1;
        chk("ld_rst_val", {24'd0, v_l}, 32'h0);
        reset_l = 1'b1; load_l = 1'b1; lv_l = 8'hF0;
        tick_l("ld_f0");
        chk("ld_f0_direct", {24'd0, v_l}, 32'hF0);
        load_l = 1'b0; en_l = 1'b0;
        tick_l("ld_hold");
        chk("ld_hold_direct", {24'd0, v_l}, 32'hF0);
        en_l = 1'b1;
        tick_l("ld_inc");
        chk("ld_inc_direct", {24'd0, v_l}, 32'hF1);
        load_l = 1'b1; lv_l = 8'h10;
        tick_l("ld_wins");
        chk("ld_wins_direct", {24'd0, v_l}, 32'h10);
        lv_l = 8'hFF;
        tick_l("ld_clamp");
        chk("ld_clamp_direct", {24'd0, v_l}, 32'hF8);
        load_l = 1'b0;
        tick_l("ld_wrap");
        chk("ld_wrap_direct", {31'd0, w_l}, 32'h1);
        for (int i = 0; i < 60; i++) begin
            load_l = ($urandom_range(0, 4) == 0);
            en_l   = ($urandom_range(0, 3) != 0);
            lv_l   = 8'($urandom_range(0, 255));
            tick_l("ld_rand");
        end
        // Reset during a load cycle wins and leaves no stale state.
        load_l = 1'b1; lv_l = 8'h55; en_l = 1'b1;
        #2 reset_l = 1'b0;
        #1;
        chk("ld_rst_async_val",  {24'd0, v_l}, 32'h0);
        chk("ld_rst_async_wrap", {31'd0, w_l}, 32'h0);
        tick_l("ld_rst_held");
        #2 reset_l = 1'b1; load_l = 1'b0;
        tick_l("ld_after_rst");
        chk("ld_after_rst_direct", {24'd0, v_l}, 32'h1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
